scs8hd_and4bb_sweep_chk: RTL and testbench
==========================================

# scs8hd_and4bb_sweep_chk

Self-checking stimulus and capture stage for the scs8hd 4-input AND cell with two inverted inputs (X = !AN & !BN & C & D).
- Drives the cell's AN/BN/C/D pins through an exhaustive Gray-code sweep and samples the cell's X after a programmable settle time.
- Compares each sample against the expected function, then reports pass/fail, the error count and the first failing vector.
- Sits directly upstream of the cell under test in the library characterization and regression benches; the cell's X feeds back into `x_obs`.

## Interface
Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling `x_obs`; legal 0..15.
- LOOPS, 1, number of full 16-vector sweeps per run; legal 1..255.
- ERR_W, 5, width of `err_cnt`; the count saturates at 2^ERR_W-1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - CLK  in  1  clock; all state updates on the rising edge.
  - RESETB  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled run request.
- x_obs  in  1  X output of the cell under test.
- an, bn, c, d  out  1 each  registered drive to the cell's AN, BN, C, D pins.
- busy  out  1  high while a run is in progress.
- done  out  1  high from the end of a run until the next accepted start.
- pass  out  1  valid when `done`=1: 1 if `err_cnt`==0.
- err_cnt  out  ERR_W  number of mismatching samples, saturating.
- fail_valid  out  1  set on the first mismatch of a run.
- fail_vec  out  4  {an,bn,c,d} of the first mismatch; holds until the next start.

## Operation
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- Vector index:
  - Index i (4 bits) counts 0..15 and wraps; the loop counter counts 0..LOOPS-1.
  - Driven vector {an,bn,c,d} = i ^ (i>>1), so exactly one pin toggles per step, including the 15->0 wrap.
- Expected value = !an & !bn & c & d. Only vector 4'b0011 expects 1.
- IDLE/DONE:
  - Pins are parked at {an,bn,c,d}=4'b1100 (expected X=0).
  - start=1 sampled -> DRIVE. On entry, err_cnt, fail_valid, fail_vec, index and loop are cleared, busy=1 and done=0.
- DRIVE: the pin registers load the current Gray vector; next state is WAIT, or SAMPLE when SETTLE_CYCLES=0.
- WAIT: stays SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: compares `x_obs` with the expected value.
  - On mismatch: err_cnt increments, saturating.
  - On the first mismatch of a run: fail_valid=1 and fail_vec=current vector.
  - Next state:
    - index<15: index+1 -> DRIVE.
    - index==15 and loop<LOOPS-1: index=0, loop+1 -> DRIVE.
    - Otherwise: DONE, with busy=0, done=1 and pins parked.
- start while busy=1 is ignored. start held high in DONE immediately begins a new run.
- x_obs equal to X or Z counts as a mismatch (use the `!==` compare semantics).

## Timing
- Reset (RESETB=0, asynchronous, any state):
  - State=IDLE, {an,bn,c,d}=4'b1100, busy=0, done=0, pass=0.
  - err_cnt=0, fail_valid=0, fail_vec=4'b0000.
  - Reset mid-run aborts the run with no partial `done`.
- Per-vector period P = SETTLE_CYCLES+2 cycles.
- Call the edge that samples start=1 edge 0. For vector k (global index across loops):
  - Pins change on edge k*P+1.
  - x_obs is sampled on edge k*P+SETTLE_CYCLES+2.
- done and busy:
  - busy rises on edge 0.
  - done rises and busy falls on edge 16*LOOPS*P+1.
  - pass is updated on the same edge as done.
- err_cnt and fail_* update on the sampling edge of the offending vector and are visible the following cycle.
- Pins are stable for P cycles per vector; there are no glitches between edges because all pin outputs are registered.

## Test plan
- Good cell: x_obs tied to a model of the AND cell, SETTLE_CYCLES=2, LOOPS=1.
  - done rises on edge 65.
  - pass=1, err_cnt=0, fail_valid=0.
- Stuck-at-0 on X:
  - err_cnt=1, fail_vec=4'b0011, pass=0.
  - The mismatch is recorded at vector index 2 (Gray 0011), i.e. on edge 2*4+4=12.
- Stuck-at-1 on X, LOOPS=2, ERR_W=3:
  - The true error count is 30, so err_cnt saturates at 7.
  - fail_vec=4'b0000 and done rises on edge 129.
- SETTLE_CYCLES=0 with an X delayed by one cycle (sampled too early) -> nonzero err_cnt. SETTLE_CYCLES=1 with the same delayed X -> pass=1.
- Start while busy: pulse start at edges 10 and 30 of a run; timing and results are identical to the good-cell case.
- RESETB=0 at edge 20 mid-sweep:
  - Outputs immediately (asynchronously) return to 1100/0/0 and err_cnt=0.
  - A new start after release completes normally.

Source files
------------

// File: rtl/scs8hd_and4bb_sweep_chk_if.sv
// Stimulus/capture bundle between the sweep checker and the and4bb cell under test.
// The master side is the checker; the slave side is the bench/cell environment.
interface scs8hd_and4bb_sweep_chk_if #(
  parameter int ERR_W = 5
);
  logic             start;
  logic             x_obs;
  logic             an;
  logic             bn;
  logic             c;
  logic             d;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [3:0]       fail_vec;

  modport master (
    input  start, x_obs,
    output an, bn, c, d, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, x_obs,
    input  an, bn, c, d, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/scs8hd_and4bb_sweep_chk.sv
// Gray-code exhaustive sweep of the and4bb cell (X = !AN & !BN & C & D) with
// settle-delayed sampling, saturating error count and first-failure capture.
module scs8hd_and4bb_sweep_chk #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 5
) (
  input  logic                           CLK,
  input  logic                           RESETB,
  scs8hd_and4bb_sweep_chk_if.master      bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;

  localparam logic [3:0]       PARK      = 4'b1100;
  localparam logic [3:0]       WAIT_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [7:0]       LOOP_LAST = 8'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

  state_t           state;
  logic [3:0]       idx;
  logic [7:0]       loop_cnt;
  logic [3:0]       wait_cnt;
  logic [3:0]       pins;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [3:0]       fail_vec;

  logic [3:0] gray;
  logic       expected;
  logic       mismatch;

  assign gray     = idx ^ (idx >> 1);
  assign expected = (pins == 4'b0011);
  // NOTE: !== makes an X or Z on x_obs count as a mismatch in simulation; synthesis treats it as !=.
  assign mismatch = (bus.x_obs !== expected);

  // NOTE: all state lives in one clocked block using non-blocking assignments only.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= IDLE;
      idx        <= '0;
      loop_cnt   <= '0;
      wait_cnt   <= '0;
      pins       <= PARK;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE && busy) begin
            // Wrap-up cycle after the last sample: err_cnt is final here.
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_cnt == '0);
            pins <= PARK;
          end else if (bus.start) begin
            state      <= DRIVE;
            idx        <= '0;
            loop_cnt   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        DRIVE: begin
          pins     <= gray;
          wait_cnt <= '0;
          state    <= (SETTLE_CYCLES == 0) ? SAMPLE : WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= SAMPLE;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= pins;
            end
          end
          if (idx != 4'd15) begin
            idx   <= idx + 4'd1;
            state <= DRIVE;
          end else if (loop_cnt != LOOP_LAST) begin
            idx      <= '0;
            loop_cnt <= loop_cnt + 8'd1;
            state    <= DRIVE;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.an         = pins[3];
  assign bus.bn         = pins[2];
  assign bus.c          = pins[1];
  assign bus.d          = pins[0];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_cnt    = err_cnt;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;

endmodule

// File: tb/tb_scs8hd_and4bb_sweep_chk.sv
// Directed bench for scs8hd_and4bb_sweep_chk: four checker instances with
// different settle/loop/width settings, each driven by a small cell model.
module tb_scs8hd_and4bb_sweep_chk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic       fvalid;
    logic [3:0] pins;
    logic [3:0] fvec;
    logic [7:0] err;
  } obs_t;

  logic CLK = 1'b0;
  logic RESETB = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Main instance cell behaviour: 0 good, 1 stuck-at-0, 2 stuck-at-1.
  int   mode = 0;
  logic start_v [4];
  obs_t obs [4];

  scs8hd_and4bb_sweep_chk_if #(.ERR_W(5)) if_m  ();
  scs8hd_and4bb_sweep_chk_if #(.ERR_W(3)) if_l2 ();
  scs8hd_and4bb_sweep_chk_if #(.ERR_W(5)) if_s0 ();
  scs8hd_and4bb_sweep_chk_if #(.ERR_W(5)) if_s1 ();

  scs8hd_and4bb_sweep_chk #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(5)) u_main (.CLK(CLK), .RESETB(RESETB), .bus(if_m));
  scs8hd_and4bb_sweep_chk #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(3)) u_l2   (.CLK(CLK), .RESETB(RESETB), .bus(if_l2));
  scs8hd_and4bb_sweep_chk #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(5)) u_s0   (.CLK(CLK), .RESETB(RESETB), .bus(if_s0));
  scs8hd_and4bb_sweep_chk #(.SETTLE_CYCLES(1), .LOOPS(1), .ERR_W(5)) u_s1   (.CLK(CLK), .RESETB(RESETB), .bus(if_s1));

  // Cell models: X = !AN & !BN & C & D, optionally stuck or delayed one clock.
  logic x_good_m, x_s0, x_s1, x_dly_s0, x_dly_s1;
  assign x_good_m = !if_m.an  & !if_m.bn  & if_m.c  & if_m.d;
  assign x_s0     = !if_s0.an & !if_s0.bn & if_s0.c & if_s0.d;
  assign x_s1     = !if_s1.an & !if_s1.bn & if_s1.c & if_s1.d;
  always_ff @(posedge CLK) begin
    x_dly_s0 <= x_s0;
    x_dly_s1 <= x_s1;
  end

  assign if_m.x_obs  = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : x_good_m;
  assign if_l2.x_obs = 1'b1;
  assign if_s0.x_obs = x_dly_s0;
  assign if_s1.x_obs = x_dly_s1;

  assign if_m.start  = start_v[0];
  assign if_l2.start = start_v[1];
  assign if_s0.start = start_v[2];
  assign if_s1.start = start_v[3];

  assign obs[0] = {if_m.busy,  if_m.done,  if_m.pass,  if_m.fail_valid,  if_m.an,  if_m.bn,  if_m.c,  if_m.d,  if_m.fail_vec,  8'(if_m.err_cnt)};
  assign obs[1] = {if_l2.busy, if_l2.done, if_l2.pass, if_l2.fail_valid, if_l2.an, if_l2.bn, if_l2.c, if_l2.d, if_l2.fail_vec, 8'(if_l2.err_cnt)};
  assign obs[2] = {if_s0.busy, if_s0.done, if_s0.pass, if_s0.fail_valid, if_s0.an, if_s0.bn, if_s0.c, if_s0.d, if_s0.fail_vec, 8'(if_s0.err_cnt)};
  assign obs[3] = {if_s1.busy, if_s1.done, if_s1.pass, if_s1.fail_valid, if_s1.an, if_s1.bn, if_s1.c, if_s1.d, if_s1.fail_vec, 8'(if_s1.err_cnt)};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Starts a run on instance w (start sampled on edge 0), optionally re-pulses
  // start on edges pa/pb, checks the Gray pins every edge and reports the edge
  // where done first reads high and where fail_valid first reads high.
  task automatic run_sweep(input int w, input int period, input int loops, input int pa, input int pb,
                           output int done_edge, output int fail_edge);
    int         limit;
    obs_t       o;
    logic [3:0] k4;
    limit     = 16 * loops * period + 20;
    done_edge = -1;
    fail_edge = -1;
    @(negedge CLK);
    start_v[w] = 1'b1;
    @(posedge CLK);
    #1;
    o = obs[w];
    check("busy_edge0", 32'(o.busy), 32'd1);
    check("done_edge0", 32'(o.done), 32'd0);
    for (int n = 1; n <= limit; n++) begin
      start_v[w] = (n == pa || n == pb);
      @(posedge CLK);
      #1;
      o = obs[w];
      if (fail_edge < 0 && o.fvalid) fail_edge = n;
      if (n <= 16 * loops * period) begin
        k4 = 4'((n - 1) / period);
        check("gray_pins", 32'(o.pins), 32'(k4 ^ (k4 >> 1)));
      end
      if (o.done) begin
        done_edge = n;
        break;
      end
    end
    start_v[w] = 1'b0;
    if (done_edge < 0) check("done_timeout", 32'(done_edge), 32'(16 * loops * period + 1));
  endtask

  task automatic check_result(input int w, input string tag, input logic pass_e, input int err_e,
                              input logic fv_e, input logic [3:0] fvec_e);
    obs_t o;
    o = obs[w];
    check({tag, "_pass"},   32'(o.pass),   32'(pass_e));
    check({tag, "_err"},    32'(o.err),    32'(err_e));
    check({tag, "_fvalid"}, 32'(o.fvalid), 32'(fv_e));
    check({tag, "_fvec"},   32'(o.fvec),   32'(fvec_e));
    check({tag, "_busy"},   32'(o.busy),   32'd0);
    check({tag, "_park"},   32'(o.pins),   32'h0c);
  endtask

  initial begin
    int   de, fe;
    obs_t o;
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    o = obs[0];
    check("rst_pins",  32'(o.pins),   32'h0c);
    check("rst_busy",  32'(o.busy),   32'd0);
    check("rst_done",  32'(o.done),   32'd0);
    check("rst_pass",  32'(o.pass),   32'd0);
    check("rst_err",   32'(o.err),    32'd0);
    check("rst_fvalid",32'(o.fvalid), 32'd0);
    check("rst_fvec",  32'(o.fvec),   32'd0);
    @(negedge CLK);
    RESETB = 1'b1;

    // Good cell, SETTLE=2, LOOPS=1.
    mode = 0;
    run_sweep(0, 4, 1, -1, -1, de, fe);
    check("good_done_edge", 32'(de), 32'd65);
    check_result(0, "good", 1'b1, 0, 1'b0, 4'b0000);

    // Restart straight from DONE with start held (level-sampled).
    run_sweep(0, 4, 1, -1, -1, de, fe);
    check("again_done_edge", 32'(de), 32'd65);
    check_result(0, "again", 1'b1, 0, 1'b0, 4'b0000);

    // Stuck-at-0: only vector 0011 (index 2) fails, recorded on edge 12.
    mode = 1;
    run_sweep(0, 4, 1, -1, -1, de, fe);
    check("sa0_done_edge", 32'(de), 32'd65);
    check("sa0_fail_edge", 32'(fe), 32'd12);
    check_result(0, "sa0", 1'b0, 1, 1'b1, 4'b0011);

    // Start pulses while busy are ignored.
    mode = 0;
    run_sweep(0, 4, 1, 10, 30, de, fe);
    check("busy_start_done_edge", 32'(de), 32'd65);
    check_result(0, "busy_start", 1'b1, 0, 1'b0, 4'b0000);

    // Stuck-at-1, LOOPS=2, ERR_W=3: 30 true errors saturate at 7.
    run_sweep(1, 4, 2, -1, -1, de, fe);
    check("sa1_done_edge", 32'(de), 32'd129);
    check("sa1_fail_edge", 32'(fe), 32'd4);
    check_result(1, "sa1", 1'b0, 7, 1'b1, 4'b0000);

    // SETTLE=0 with one-cycle-late X: vectors 0011 and 0010 sample the wrong value.
    run_sweep(2, 2, 1, -1, -1, de, fe);
    check("early_done_edge", 32'(de), 32'd33);
    check("early_fail_edge", 32'(fe), 32'd6);
    check_result(2, "early", 1'b0, 2, 1'b1, 4'b0011);

    // SETTLE=1 with the same late X samples correctly.
    run_sweep(3, 3, 1, -1, -1, de, fe);
    check("settled_done_edge", 32'(de), 32'd49);
    check_result(3, "settled", 1'b1, 0, 1'b0, 4'b0000);

    // Reset mid-sweep at edge 20 with a stuck-at-1 cell (4 errors by then).
    mode = 2;
    @(negedge CLK);
    start_v[0] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start_v[0] = 1'b0;
    repeat (20) @(posedge CLK);
    #1;
    o = obs[0];
    check("mid_err",  32'(o.err),  32'd4);
    check("mid_pins", 32'(o.pins), 32'b0110);
    check("mid_busy", 32'(o.busy), 32'd1);
    RESETB = 1'b0;
    #1;
    o = obs[0];
    check("arst_pins",   32'(o.pins),   32'h0c);
    check("arst_busy",   32'(o.busy),   32'd0);
    check("arst_done",   32'(o.done),   32'd0);
    check("arst_err",    32'(o.err),    32'd0);
    check("arst_fvalid", 32'(o.fvalid), 32'd0);
    @(negedge CLK);
    RESETB = 1'b1;
    mode = 0;
    run_sweep(0, 4, 1, -1, -1, de, fe);
    check("post_rst_done_edge", 32'(de), 32'd65);
    check_result(0, "post_rst", 1'b1, 0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
